// File: rtl/wb_ctrl_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_ctrl_pkg                                                                |
// | Shared types for the writeback control pipe: opcodes, wb_sel, stage entry. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package wb_ctrl_pkg;

  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic       load;
    logic       illegal;
    wb_sel_e    sel;
    logic [4:0] rd;
  } stage_t;

  // Empty slots must look like a harmless ALU no-op to everything downstream.
  function automatic stage_t present_entry(input stage_t e);
    stage_t v;
    v = e;
    if (!e.valid) begin
      v.wen     = 1'b0;
      v.load    = 1'b0;
      v.illegal = 1'b0;
      v.sel     = WB_ALU;
      v.rd      = 5'd0;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ctrl_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_ctrl_pipe_if                                                            |
// | Decode-side inputs and writeback/hazard outputs of the control pipe.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface wb_ctrl_pipe_if #(
  parameter int DEPTH = 3,
  parameter int NREG  = 32
);
  logic [31:0]        inst_i;
  logic               inst_valid_i;
  logic               stall_i;
  logic               flush_i;
  logic [1:0]         wb_sel_o;
  logic               reg_wen_o;
  logic [4:0]         wb_rd_o;
  logic               illegal_o;
  logic [DEPTH-1:0]   stage_wen_o;
  logic [5*DEPTH-1:0] stage_rd_o;
  logic [DEPTH-1:0]   stage_load_o;
  logic [NREG-1:0]    busy_o;
  logic               load_use_o;

  modport master (
    output inst_i, inst_valid_i, stall_i, flush_i,
    input  wb_sel_o, reg_wen_o, wb_rd_o, illegal_o, stage_wen_o,
           stage_rd_o, stage_load_o, busy_o, load_use_o
  );

  modport slave (
    input  inst_i, inst_valid_i, stall_i, flush_i,
    output wb_sel_o, reg_wen_o, wb_rd_o, illegal_o, stage_wen_o,
           stage_rd_o, stage_load_o, busy_o, load_use_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_ctrl_pipe_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_ctrl_dec                                                                |
// | Combinational RV32I decode of writeback control and source usage.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_ctrl_dec
  import wb_ctrl_pkg::*;
(
  input  wire logic [31:0] inst,
  output wb_sel_e          sel,
  output logic             wen,
  output logic             load,
  output logic             illegal,
  output logic [4:0]       rd,
  output logic             use_rs1,
  output logic             use_rs2
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_wen;

  assign w_opcode = inst[6:0];
  assign w_funct3 = inst[14:12];
  assign w_funct7 = inst[31:25];
  assign rd       = inst[11:7];
  assign wen      = w_wen && (inst[11:7] != 5'd0);

  always_comb begin
    sel     = WB_ALU;
    w_wen   = 1'b0;
    load    = 1'b0;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (w_opcode)
      c_op_reg: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case ({w_funct7, w_funct3})
          10'h000, 10'h001, 10'h002, 10'h003, 10'h004,
          10'h005, 10'h006, 10'h007, 10'h100, 10'h105: w_wen = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      c_op_imm: begin
        use_rs1 = 1'b1;
        w_wen   = 1'b1;
      end
      c_op_load: begin
        use_rs1 = 1'b1;
        case (w_funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            sel   = WB_MEM;
            w_wen = 1'b1;
            load  = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      c_op_store: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (w_funct3 <= 3'b010) sel = WB_MEM;
        else                    illegal = 1'b1;
      end
      c_op_branch: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        sel     = WB_MEM;
      end
      c_op_lui, c_op_auipc: w_wen = 1'b1;
      c_op_jal: begin
        sel   = WB_PC4;
        w_wen = 1'b1;
      end
      c_op_jalr: begin
        use_rs1 = 1'b1;
        sel     = WB_PC4;
        w_wen   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_ctrl_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_ctrl_pipe                                                               |
// | Writeback control shift pipe with busy bitmap and load-use detection.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_ctrl_pipe
  import wb_ctrl_pkg::*;
#(
  parameter int DEPTH        = 3,
  parameter int FLUSH_STAGES = 2,
  parameter int NREG         = 32
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  wb_ctrl_pipe_if.slave     bus
);

  wb_sel_e    w_dec_sel;
  logic       w_dec_wen;
  logic       w_dec_load;
  logic       w_dec_illegal;
  logic [4:0] w_dec_rd;
  logic       w_use_rs1;
  logic       w_use_rs2;

  stage_t          w_cap;
  stage_t          w_shift [DEPTH];
  stage_t          w_view  [DEPTH];
  stage_t          r_stage [DEPTH];
  logic [NREG-1:0] w_busy;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;

  wb_ctrl_dec u_dec (
    .inst    (bus.inst_i),
    .sel     (w_dec_sel),
    .wen     (w_dec_wen),
    .load    (w_dec_load),
    .illegal (w_dec_illegal),
    .rd      (w_dec_rd),
    .use_rs1 (w_use_rs1),
    .use_rs2 (w_use_rs2)
  );

  always_comb begin
    w_cap = '0;
    if (bus.inst_valid_i) begin
      w_cap.valid   = 1'b1;
      w_cap.wen     = w_dec_wen;
      w_cap.load    = w_dec_load;
      w_cap.illegal = w_dec_illegal;
      w_cap.sel     = w_dec_sel;
      w_cap.rd      = w_dec_rd;
    end
  end

  always_comb begin
    w_shift[0] = w_cap;
    for (int k = 1; k < DEPTH; k++) begin
      w_shift[k] = r_stage[k-1];
    end
  end

  // Flush beats stall for the young stages; older stages only move on !stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (bus.flush_i && (k < FLUSH_STAGES)) begin
          r_stage[k] <= '0;
        end else if (!bus.stall_i) begin
          r_stage[k] <= w_shift[k];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_view[k] = present_entry(r_stage[k]);
    end
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_out
      assign bus.stage_wen_o[k]        = w_view[k].wen;
      assign bus.stage_load_o[k]       = w_view[k].load;
      assign bus.stage_rd_o[5*k +: 5]  = w_view[k].rd;
    end
  endgenerate

  assign bus.wb_sel_o  = w_view[DEPTH-1].sel;
  assign bus.reg_wen_o = w_view[DEPTH-1].wen;
  assign bus.wb_rd_o   = w_view[DEPTH-1].rd;
  assign bus.illegal_o = w_view[DEPTH-1].illegal;

  // Register 0 is never reported busy since its writes are always suppressed.
  always_comb begin
    w_busy = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_view[k].wen && (int'(w_view[k].rd) == r)) begin
          w_busy[r] = 1'b1;
        end
      end
    end
  end

  assign bus.busy_o = w_busy;

  assign w_rs1 = bus.inst_i[19:15];
  assign w_rs2 = bus.inst_i[24:20];

  assign bus.load_use_o = bus.inst_valid_i && w_view[0].load &&
                          (w_view[0].rd != 5'd0) &&
                          ((w_use_rs1 && (w_rs1 == w_view[0].rd)) ||
                           (w_use_rs2 && (w_rs2 == w_view[0].rd)));

endmodule
`default_nettype wire

// File: tb/tb_wb_ctrl_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_ctrl_pipe                                                            |
// | Directed vector bench for wb_ctrl_pipe (DEPTH=3, FLUSH_STAGES=2).          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wb_ctrl_pipe;

  localparam int DEPTH = 3;
  localparam int FS    = 2;
  localparam int NREG  = 32;
  localparam int NV    = 18;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  wb_ctrl_pipe_if #(.DEPTH(DEPTH), .NREG(NREG)) bus ();

  wb_ctrl_pipe #(.DEPTH(DEPTH), .FLUSH_STAGES(FS), .NREG(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [1:0]  sel;
    logic        wen;
    logic        ill;
    logic        ld;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic v, input logic st, input logic fl);
    bus.inst_i       = inst;
    bus.inst_valid_i = v;
    bus.stall_i      = st;
    bus.flush_i      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0]  = '{32'h002082B3, 2'b01, 1'b1, 1'b0, 1'b0, 5'd5};
    vecs[1]  = '{32'h402082B3, 2'b01, 1'b1, 1'b0, 1'b0, 5'd5};
    vecs[2]  = '{32'h4020D2B3, 2'b01, 1'b1, 1'b0, 1'b0, 5'd5};
    vecs[3]  = '{32'h402092B3, 2'b01, 1'b0, 1'b1, 1'b0, 5'd5};
    vecs[4]  = '{32'h022081B3, 2'b01, 1'b0, 1'b1, 1'b0, 5'd3};
    vecs[5]  = '{32'h0000A303, 2'b00, 1'b1, 1'b0, 1'b1, 5'd6};
    vecs[6]  = '{32'h0000B303, 2'b01, 1'b0, 1'b1, 1'b0, 5'd6};
    vecs[7]  = '{32'h0020A023, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[8]  = '{32'h00208063, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[9]  = '{32'h12345537, 2'b01, 1'b1, 1'b0, 1'b0, 5'd10};
    vecs[10] = '{32'h00000597, 2'b01, 1'b1, 1'b0, 1'b0, 5'd11};
    vecs[11] = '{32'h000000EF, 2'b10, 1'b1, 1'b0, 1'b0, 5'd1};
    vecs[12] = '{32'h000100E7, 2'b10, 1'b1, 1'b0, 1'b0, 5'd1};
    vecs[13] = '{32'h00000013, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[14] = '{32'hFFFFFFFF, 2'b01, 1'b0, 1'b1, 1'b0, 5'd31};
    vecs[15] = '{32'h0020B023, 2'b01, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[16] = '{32'h00002003, 2'b00, 1'b0, 1'b0, 1'b1, 5'd0};
    vecs[17] = '{32'h4030D213, 2'b01, 1'b1, 1'b0, 1'b0, 5'd4};

    // Reset state, with a clock running and decode inputs active
    rst_n = 1'b0;
    drive(32'h006303B3, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_wen",       bus.reg_wen_o,   0);
    chk("rst_sel",       bus.wb_sel_o,    2'b01);
    chk("rst_rd",        bus.wb_rd_o,     0);
    chk("rst_ill",       bus.illegal_o,   0);
    chk("rst_busy",      bus.busy_o,      0);
    chk("rst_loaduse",   bus.load_use_o,  0);
    chk("rst_stage_wen", bus.stage_wen_o, 0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Decoder table, streamed back to back through the pipe
    for (int i = 0; i < NV + DEPTH - 1; i++) begin
      if (i < NV) drive(vecs[i].inst, 1'b1, 1'b0, 1'b0);
      else        drive(32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i < NV) begin
        chk($sformatf("v%0d_s0_wen", i),  bus.stage_wen_o[0],  vecs[i].wen);
        chk($sformatf("v%0d_s0_load", i), bus.stage_load_o[0], vecs[i].ld);
        chk($sformatf("v%0d_s0_rd", i),   bus.stage_rd_o[4:0], vecs[i].rd);
      end
      if (i >= DEPTH - 1) begin
        chk($sformatf("v%0d_sel", i-2), bus.wb_sel_o,  vecs[i-2].sel);
        chk($sformatf("v%0d_wen", i-2), bus.reg_wen_o, vecs[i-2].wen);
        chk($sformatf("v%0d_ill", i-2), bus.illegal_o, vecs[i-2].ill);
        chk($sformatf("v%0d_rd", i-2),  bus.wb_rd_o,   vecs[i-2].rd);
      end
    end
    tick();
    chk("drain_stage_wen", bus.stage_wen_o, 0);

    // add x5: busy for exactly three cycles
    drive(32'h002082B3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    chk("add_busy_c1", bus.busy_o, 32'h20);
    tick();
    chk("add_busy_c2", bus.busy_o, 32'h20);
    chk("add_wen_early", bus.reg_wen_o, 0);
    tick();
    chk("add_busy_c3", bus.busy_o, 32'h20);
    chk("add_final", {bus.wb_sel_o, bus.reg_wen_o, bus.wb_rd_o}, {2'b01, 1'b1, 5'd5});
    tick();
    chk("add_busy_c4", bus.busy_o, 0);
    chk("add_retired", bus.reg_wen_o, 0);

    // lw x6 then add x7,x6,x6: load-use while add sits at decode
    drive(32'h0000A303, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h006303B3, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_hit", bus.load_use_o, 1);
    drive(32'h006303B3, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_invalid_dec", bus.load_use_o, 0);
    drive(32'h000303B7, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_lui_nosrc", bus.load_use_o, 0);
    drive(32'h00008393, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_other_rs", bus.load_use_o, 0);
    drive(32'h00630393, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_addi_rs1", bus.load_use_o, 1);
    drive(32'h006303B3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h006303B3, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stage0_not_load", bus.load_use_o, 0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lw_final", {bus.wb_sel_o, bus.reg_wen_o, bus.wb_rd_o}, {2'b00, 1'b1, 5'd6});
    tick();
    tick();
    tick();

    // addi x0 then mul x3: never busy, mul flagged illegal at writeback
    drive(32'h00000013, 1'b1, 1'b0, 1'b0);
    tick();
    chk("nop_busy", bus.busy_o, 0);
    drive(32'h022081B3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    chk("mul_busy_c1", bus.busy_o, 0);
    tick();
    chk("nop_final", {bus.reg_wen_o, bus.illegal_o}, 2'b00);
    chk("mul_busy_c2", bus.busy_o, 0);
    tick();
    chk("mul_final", {bus.reg_wen_o, bus.illegal_o}, 2'b01);
    chk("mul_busy_c3", bus.busy_o, 0);
    tick();

    // Three in flight, stall two cycles, then flush with stall held
    drive(32'h002082B3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h00100313, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h000013B7, 1'b1, 1'b0, 1'b0);
    tick();
    chk("full_stage_wen", bus.stage_wen_o, 3'b111);
    chk("full_busy", bus.busy_o, 32'hE0);
    drive(32'h00100413, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("stall%0d_stage_wen", c), bus.stage_wen_o, 3'b111);
      chk($sformatf("stall%0d_final", c), {bus.reg_wen_o, bus.wb_rd_o}, {1'b1, 5'd5});
      chk($sformatf("stall%0d_rd", c), bus.stage_rd_o, {5'd5, 5'd6, 5'd7});
    end
    drive(32'h00100413, 1'b1, 1'b1, 1'b1);
    tick();
    chk("flush_stage_wen", bus.stage_wen_o, 3'b100);
    chk("flush_busy", bus.busy_o, 32'h20);
    chk("flush_final", {bus.reg_wen_o, bus.wb_rd_o}, {1'b1, 5'd5});
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_flush_stage_wen", bus.stage_wen_o, 0);
    chk("post_flush_final", {bus.wb_sel_o, bus.reg_wen_o}, {2'b01, 1'b0});

    // Flush also kills the instruction at decode
    drive(32'h002082B3, 1'b1, 1'b0, 1'b1);
    tick();
    chk("flush_decode", bus.stage_wen_o, 0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset with the pipe full
    drive(32'h002082B3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h00100313, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h0000A303, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h006303B3, 1'b1, 1'b0, 1'b0);
    #1;
    chk("pre_rst_loaduse", bus.load_use_o, 1);
    chk("pre_rst_wen", bus.reg_wen_o, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_wen",       bus.reg_wen_o,   0);
    chk("arst_sel",       bus.wb_sel_o,    2'b01);
    chk("arst_rd",        bus.wb_rd_o,     0);
    chk("arst_ill",       bus.illegal_o,   0);
    chk("arst_busy",      bus.busy_o,      0);
    chk("arst_loaduse",   bus.load_use_o,  0);
    chk("arst_stage_wen", bus.stage_wen_o, 0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h002082B3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    chk("after_rst_stage_wen", bus.stage_wen_o, 3'b001);
    chk("after_rst_busy", bus.busy_o, 32'h20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
